// File: rtl/kf_pkg.sv
// ============================================================================
// Module      : kf_pkg
// Description : Shared definitions for the Kalman-filter matrix-vector
//               arbiter: default data format, FSM state encoding and
//               requester-count legality range.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kf_pkg;

    // Default signed fixed-point format
    localparam int KF_N_DEF    = 20;
    localparam int KF_FRAC_DEF = 10;

    // Legal range for the number of requesters
    localparam int KF_NREQ_MIN = 2;
    localparam int KF_NREQ_MAX = 4;

    // Arbiter FSM state encoding
    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_START = 2'd1;
    localparam logic [1:0] C_ST_WAIT  = 2'd2;
    localparam logic [1:0] C_ST_RESP  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/est_output_serial.sv
// ============================================================================
// Module      : est_output_serial
// Description : Serial 2x2 matrix-vector engine, y = M*v. One shared
//               multiplier walks the four products over four cycles
//               (c0..c3 starting in the start cycle). done pulses the cycle
//               after c3. Rows are truncated to bits [FRAC+N-1:FRAC] with
//               wrap-around, no rounding or saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module est_output_serial
    import kf_pkg::*;
#(
    parameter int N    = KF_N_DEF,
    parameter int FRAC = KF_FRAC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [N-1:0] m00,
    input  logic signed [N-1:0] m01,
    input  logic signed [N-1:0] m10,
    input  logic signed [N-1:0] m11,
    input  logic signed [N-1:0] v0,
    input  logic signed [N-1:0] v1,
    output logic                done,
    output logic signed [N-1:0] y0,
    output logic signed [N-1:0] y1
);

    logic [1:0]            r_step;
    logic                  r_run;
    logic                  r_done;
    logic signed [2*N-1:0] r_acc0;
    logic signed [2*N-1:0] r_acc1;

    logic                  w_step_en;
    logic [1:0]            w_sel;
    logic signed [N-1:0]   w_a;
    logic signed [N-1:0]   w_b;
    logic signed [2*N-1:0] w_prod;
    logic                  w_unused_bits;

    // A start cycle always executes product c0; later steps follow r_step
    assign w_step_en = start | r_run;
    assign w_sel     = start ? 2'd0 : r_step;

    // Operand pair for the product computed this cycle
    always_comb begin
        w_a = m00;
        w_b = v0;
        case (w_sel)
            2'd0:    begin w_a = m00; w_b = v0; end
            2'd1:    begin w_a = m01; w_b = v1; end
            2'd2:    begin w_a = m10; w_b = v0; end
            default: begin w_a = m11; w_b = v1; end
        endcase
    end

    // Full-precision signed product
    assign w_prod = (2*N)'(w_a) * (2*N)'(w_b);

    // Step sequencer and row accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step <= 2'd0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
            r_acc0 <= '0;
            r_acc1 <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_step_en) begin
                case (w_sel)
                    2'd0:    r_acc0 <= w_prod;
                    2'd1:    r_acc0 <= r_acc0 + w_prod;
                    2'd2:    r_acc1 <= w_prod;
                    default: r_acc1 <= r_acc1 + w_prod;
                endcase
                r_step <= w_sel + 2'd1;
                r_run  <= (w_sel != 2'd3);
                r_done <= (w_sel == 2'd3);
            end
        end
    end

    assign done = r_done;
    assign y0   = r_acc0[FRAC+N-1:FRAC];
    assign y1   = r_acc1[FRAC+N-1:FRAC];

    // Bits outside the output window are intentionally discarded
    assign w_unused_bits = ^{r_acc0[2*N-1:FRAC+N], r_acc0[FRAC-1:0],
                             r_acc1[2*N-1:FRAC+N], r_acc1[FRAC-1:0]};

endmodule

`default_nettype wire

// File: rtl/kf_matvec_arbiter.sv
// ============================================================================
// Module      : kf_matvec_arbiter
// Description : Round-robin arbiter/sequencer sharing one serial 2x2
//               matrix-vector engine among NREQ Kalman-filter requesters.
//               Grants a winner, starts the engine, captures both rows and
//               returns them with a one-cycle per-requester DONE pulse.
//               Optional macro KF_ARB_STATS_EN adds a 16-bit wrapping
//               completed-operation counter on OP_CNT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kf_matvec_arbiter
    import kf_pkg::*;
#(
    parameter int N    = KF_N_DEF,
    parameter int FRAC = KF_FRAC_DEF,
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*4*N-1:0]   m_flat,
    input  logic [NREQ*2*N-1:0]   v_flat,
    output logic [NREQ-1:0]       GNT,
    output logic [NREQ-1:0]       DONE,
    output logic [N-1:0]          Y0,
    output logic [N-1:0]          Y1,
`ifdef KF_ARB_STATS_EN
    output logic [15:0]           OP_CNT,
`endif
    output logic                  BUSY
);

    generate
        if ((NREQ < KF_NREQ_MIN) || (NREQ > KF_NREQ_MAX)) begin : g_nreq_illegal
            $error("kf_matvec_arbiter: NREQ out of legal range");
        end
    endgenerate

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [1:0]          r_gidx;
    logic [1:0]          r_ptr;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_done;
    logic [N-1:0]        r_y0;
    logic [N-1:0]        r_y1;

    logic                w_win_found;
    logic [1:0]          w_win_idx;
    logic [NREQ-1:0]     w_win_onehot;
    logic [NREQ-1:0]     w_gidx_onehot;
    logic [1:0]          w_ptr_next;
    logic                w_eng_start;
    logic                w_busy;
    logic                w_capture;

    logic [4*N-1:0]      w_m;
    logic [2*N-1:0]      w_v;
    logic                w_eng_done;
    logic signed [N-1:0] w_eng_y0;
    logic signed [N-1:0] w_eng_y1;

    // Round-robin search starting at r_ptr
    always_comb begin
        int v_idx;
        w_win_found = 1'b0;
        w_win_idx   = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
            if (!w_win_found && req[v_idx]) begin
                w_win_found = 1'b1;
                w_win_idx   = 2'(v_idx);
            end
        end
    end

    // One-hot forms of the winner and the current grant, and the next pointer
    always_comb begin
        w_win_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << w_win_idx;
        w_gidx_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_gidx;
        w_ptr_next    = (int'(r_gidx) + 1 >= NREQ) ? 2'd0 : r_gidx + 2'd1;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_ST_IDLE:  if (w_win_found) w_next_state = C_ST_START;
            C_ST_START: w_next_state = C_ST_WAIT;
            C_ST_WAIT:  if (w_eng_done) w_next_state = C_ST_RESP;
            default:    w_next_state = C_ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_eng_start = (r_state == C_ST_START);
        w_busy      = (r_state != C_ST_IDLE);
        w_capture   = (r_state == C_ST_WAIT) && w_eng_done;
    end

    // Grant latch, result capture, DONE pulse and pointer advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt  <= '0;
            r_gidx <= 2'd0;
            r_ptr  <= 2'd0;
            r_done <= '0;
            r_y0   <= '0;
            r_y1   <= '0;
        end else begin
            r_done <= '0;
            if ((r_state == C_ST_IDLE) && w_win_found) begin
                r_gnt  <= w_win_onehot;
                r_gidx <= w_win_idx;
            end
            if (w_capture) begin
                r_y0   <= w_eng_y0;
                r_y1   <= w_eng_y1;
                r_done <= w_gidx_onehot;
                r_gnt  <= '0;
                r_ptr  <= w_ptr_next;
            end
        end
    end

`ifdef KF_ARB_STATS_EN
    logic [15:0] r_op_cnt;

    // Completed-operation counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_cnt <= 16'd0;
        end else if (w_capture) begin
            r_op_cnt <= r_op_cnt + 16'd1;
        end
    end

    assign OP_CNT = r_op_cnt;
`endif

    // Engine operands come straight from the granted requester's slice
    assign w_m = m_flat[int'(r_gidx)*4*N +: 4*N];
    assign w_v = v_flat[int'(r_gidx)*2*N +: 2*N];

    est_output_serial #(
        .N    (N),
        .FRAC (FRAC)
    ) U_ENG (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_eng_start),
        .m00   (w_m[0*N +: N]),
        .m01   (w_m[1*N +: N]),
        .m10   (w_m[2*N +: N]),
        .m11   (w_m[3*N +: N]),
        .v0    (w_v[0*N +: N]),
        .v1    (w_v[1*N +: N]),
        .done  (w_eng_done),
        .y0    (w_eng_y0),
        .y1    (w_eng_y1)
    );

    assign GNT  = r_gnt;
    assign DONE = r_done;
    assign Y0   = r_y0;
    assign Y1   = r_y1;
    assign BUSY = w_busy;

endmodule

`default_nettype wire
